packet_counter: RTL
===================

# packet_counter

Counts packets drained from the four output FIFOs (fifo4..fifo7) of the switch integration, and returns any port's count on request. It sits directly downstream of the output FIFOs and observes the same pop strobes and empty flags that drain them. It is the consumer-side statistics block that answers the bench's `req`/`idx` queries with a 5-bit `counter_out`. It has a small control FSM that tracks init and traffic activity.

## Interface
- `NPORT`, default 4: number of output FIFOs observed.
- `CNT_W`, default 5: counter width.
- `clk` input, 1 bit: single clock; all logic on posedge.
- `reset` input, 1 bit: asynchronous, active-low reset; 0 clears everything immediately.
- `init` input, 1 bit: configuration phase; while 1, counters are held at 0.
- `pop` input, NPORT bits: pop strobe per output FIFO; bit 0 is fifo4 and bit 3 is fifo7.
- `empty` input, NPORT bits: empty flag per output FIFO, same cycle as `pop`.
- `req` input, 1 bit: read request for one counter.
- `idx` input, 2 bits: which counter to read (0 = fifo4 … 3 = fifo7).
- `counter_out` output, CNT_W bits: registered read data.
- `valid` output, 1 bit: `counter_out` is valid this cycle.
- `idle` output, 1 bit: FSM is in IDLE.
- `state` output, 2 bits: current FSM state, for debug.

## Operation
- States: RESET=0, INIT=1, IDLE=2, ACTIVE=3.
- RESET
  - Entered asynchronously while `reset`=0.
  - On the first posedge with `reset`=1, goes to INIT if `init`=1, otherwise to IDLE.
- INIT
  - All counters are cleared every cycle.
  - `req` is ignored: `valid`=0.
  - Goes to IDLE on the first posedge with `init`=0.
- IDLE
  - Goes to ACTIVE on any counted pop.
  - Goes to INIT if `init`=1.
- ACTIVE
  - Goes to IDLE when all `empty` bits are 1 and no `pop` bit is 1.
  - Goes to INIT if `init`=1.
  - `init` takes priority over every other transition.
- Counted pop: `pop[i]`=1 and `empty[i]`=0 at a posedge. Counter i then increments by 1.
- A pop on an empty FIFO (`pop[i]`=1 and `empty[i]`=1) is ignored and does not count.
- Counting happens only in IDLE and ACTIVE. All four counters count independently in the same cycle.
- Read: `req`=1 at a posedge, in IDLE or ACTIVE, loads `counter_out` with the counter selected by `idx` and sets `valid`=1.
- With `req`=0, `valid`=0 and `counter_out` holds its last value.
- Width rule: counters are CNT_W bits, unsigned. Default behaviour wraps modulo 2^CNT_W (31 → 0).

## Timing
- Reset values: `counter_out`=0, `valid`=0, `idle`=0, `state`=RESET, all counters 0.
- Count latency: a pop sampled at edge N is visible in a read requested at edge N+1 or later.
- Read latency: one cycle. `req` sampled at edge N gives `counter_out`/`valid` after edge N.
- Back-to-back `req` is allowed and returns one result per cycle.
- Simultaneous pop and read of the same index at edge N: the read returns the pre-increment value.
- `init` rising in ACTIVE: the counter clear and the state change both take effect at the same edge. A `req` at that edge returns `valid`=0.
- Reset asserted mid-operation: everything clears asynchronously. No partial count survives.
- `idle` equals (`state`==IDLE), registered.

## Configuration
- Macro: `PACKET_COUNTER_SATURATE_EN`.
- Defined: a counter at 2^CNT_W−1 stays there on further counted pops (31 stays 31).
- Undefined: counters wrap (31 → 0).
- No other behaviour changes with the macro.

## Structure
- Shared package `switch_pkg`:
  - state encodings RESET/INIT/IDLE/ACTIVE;
  - NPORT;
  - CNT_W;
  - IDX_W=2.
  - The FIFO, switch and bench blocks use the same package.
- Sub-module `port_counter`, one instance per port:
  - inputs: `clk`, `reset`, `clr`, `inc`;
  - output: `count`;
  - the saturate/wrap choice lives here.
- Top level contains the FSM, the pop qualification (`pop` & ~`empty`) and the read-mux register.

## Test plan
- Reset/init: hold `reset`=0 for 3 cycles, then release with `init`=1 for 5 cycles, then `init`=0.
  - Expect `state` to step RESET → INIT → IDLE.
  - Expect all outputs 0.
  - Expect `req` during INIT to give `valid`=0.
- Basic count: pop all four ports 6 times with `empty`=0, then `req` idx=0..3.
  - Expect `counter_out`=6 for each port, `valid`=1 one cycle after each `req`.
  - Expect `state`=ACTIVE during the pops and IDLE once all `empty`=1.
- Underflow: pop port 3 twice with `empty[3]`=1.
  - Expect counter 3 unchanged.
- Same-cycle read: counter 1 = 4; pop port 1 and `req` idx=1 at the same edge.
  - Expect `counter_out`=4; the next `req` returns 5.
- Overflow: 33 counted pops on port 2.
  - Without the macro: `counter_out`=1.
  - With `PACKET_COUNTER_SATURATE_EN`: `counter_out`=31.
- Mid-operation clears with counters nonzero:
  - Assert `init`=1 for 1 cycle: expect all counters to read 0 afterwards.
  - Drop `reset` between two clock edges: expect immediate `state`=RESET and `counter_out`=0.

Source files
------------

// File: rtl/switch_pkg.sv
// Shared switch-integration package: port count, counter widths and the
// packet_counter FSM state encodings.
package switch_pkg;

    localparam int unsigned NPORT = 4;
    localparam int unsigned CNT_W = 5;
    localparam int unsigned IDX_W = 2;
    localparam int unsigned ST_W  = 2;

    localparam logic [ST_W-1:0] ST_RESET  = 2'd0;
    localparam logic [ST_W-1:0] ST_INIT   = 2'd1;
    localparam logic [ST_W-1:0] ST_IDLE   = 2'd2;
    localparam logic [ST_W-1:0] ST_ACTIVE = 2'd3;

endpackage

// File: rtl/packet_counter_if.sv
// Observation/query bus of packet_counter: FIFO pop/empty taps, read request
// and read response. master drives the taps and requests, slave is the counter.
interface packet_counter_if #(
    parameter int unsigned NPORT = switch_pkg::NPORT,
    parameter int unsigned CNT_W = switch_pkg::CNT_W,
    parameter int unsigned IDX_W = switch_pkg::IDX_W
);
    logic                         init;
    logic [NPORT-1:0]             pop;
    logic [NPORT-1:0]             empty;
    logic                         req;
    logic [IDX_W-1:0]             idx;
    logic [CNT_W-1:0]             counter_out;
    logic                         valid;
    logic                         idle;
    logic [switch_pkg::ST_W-1:0]  state;

    modport master (
        output init, pop, empty, req, idx,
        input  counter_out, valid, idle, state
    );

    modport slave (
        input  init, pop, empty, req, idx,
        output counter_out, valid, idle, state
    );
endinterface

// File: rtl/port_counter.sv
// One per-port packet counter with synchronous clear. Wraps by default;
// saturates at all-ones when PACKET_COUNTER_SATURATE_EN is defined.
module port_counter #(
    parameter int unsigned CNT_W = switch_pkg::CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc) begin
`ifdef PACKET_COUNTER_SATURATE_EN
            if (count != {CNT_W{1'b1}}) begin
                count <= count + CNT_W'(1);
            end
`else
            count <= count + CNT_W'(1);
`endif
        end
    end

endmodule

// File: rtl/packet_counter.sv
// Per-port drained-packet statistics for the output FIFOs with a registered
// read port. Optional saturation via PACKET_COUNTER_SATURATE_EN.
module packet_counter #(
    parameter int unsigned NPORT = switch_pkg::NPORT,
    parameter int unsigned CNT_W = switch_pkg::CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    packet_counter_if.slave  bus
);
    import switch_pkg::*;

    logic [ST_W-1:0]  state_q;
    logic [ST_W-1:0]  state_d;
    logic             idle_q;
    logic [CNT_W-1:0] rd_data_q;
    logic             rd_valid_q;

    logic [NPORT-1:0] hit_c;
    logic [NPORT-1:0] inc_c;
    logic             run_c;
    logic             clr_c;
    logic             rd_en_c;
    logic             drained_c;

    logic [CNT_W-1:0] cnt [NPORT];

    // A pop only counts when the FIFO actually had data to give.
    assign hit_c     = bus.pop & ~bus.empty;
    assign run_c     = (state_q == ST_IDLE) || (state_q == ST_ACTIVE);
    assign drained_c = (&bus.empty) && !(|bus.pop);
    // init clears at the same edge it moves the FSM to INIT, even from ACTIVE.
    assign clr_c     = bus.init || (state_q == ST_INIT);
    assign inc_c     = (run_c && !bus.init) ? hit_c : '0;
    assign rd_en_c   = bus.req && run_c && !bus.init;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_RESET;
            idle_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idle_q  <= (state_d == ST_IDLE);
        end
    end

    always_comb begin
        state_d = state_q;
        if (bus.init) begin
            state_d = ST_INIT;
        end else begin
            case (state_q)
                ST_INIT:   state_d = ST_IDLE;
                ST_IDLE:   state_d = (|hit_c) ? ST_ACTIVE : ST_IDLE;
                ST_ACTIVE: state_d = drained_c ? ST_IDLE : ST_ACTIVE;
                default:   state_d = ST_IDLE;
            endcase
        end
    end

    // Read register samples the pre-increment count of the same edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            rd_valid_q <= rd_en_c;
            if (rd_en_c) begin
                rd_data_q <= cnt[bus.idx];
            end
        end
    end

    for (genvar i = 0; i < NPORT; i++) begin : g_port
        port_counter #(.CNT_W(CNT_W)) u_cnt (
            .clk   (clk),
            .reset (reset),
            .clr   (clr_c),
            .inc   (inc_c[i]),
            .count (cnt[i])
        );
    end

    assign bus.state       = state_q;
    assign bus.idle        = idle_q;
    assign bus.counter_out = rd_data_q;
    assign bus.valid       = rd_valid_q;

endmodule
